// File: rtl/sram_model_param.sv
// rtl/sram_model_param.sv - parameterised SRAM model with pipelined reads and byte-lane writes
// Optional protocol checking on err: define SRAM_PROTOCOL_CHECK_EN
module sram_model_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int DEPTH    = 64,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  inout  wire  [DATA_W-1:0]   SRAM_DQ,
  input  logic [ADDR_W-1:0]   SRAM_ADDR,
  input  logic [DATA_W/8-1:0] SRAM_BE_N,
  input  logic                SRAM_WE_N,
  input  logic                SRAM_CE_N,
  input  logic                SRAM_OE_N,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt,
  output logic                err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1   = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = AW1'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [READ_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0] pipe_data [READ_LAT];

  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             wr_acc;
  logic             rd_acc;
  logic             drive;

  assign in_range = ({1'b0, SRAM_ADDR} < DEPTH_LIM);
  assign idx      = SRAM_ADDR[IDX_W-1:0];
  assign wr_acc   = !SRAM_CE_N && !SRAM_WE_N;
  // Write wins over output enable: a cycle with both low is never a read
  assign rd_acc   = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_vld <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      for (int i = 1; i < READ_LAT; i++) pipe_vld[i] <= pipe_vld[i-1];
      if (wr_acc && in_range) begin
        for (int b = 0; b < NB; b++) begin
          if (!SRAM_BE_N[b]) mem[idx][8*b +: 8] <= SRAM_DQ[8*b +: 8];
        end
      end
      if (rd_acc && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if (wr_acc && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  // Data is snapshotted at accept time, so later writes never disturb reads in flight
  always_ff @(posedge clk) begin
    if (rd_acc) pipe_data[0] <= in_range ? mem[idx] : '0;
    for (int i = 1; i < READ_LAT; i++) pipe_data[i] <= pipe_data[i-1];
  end

  assign drive   = pipe_vld[READ_LAT-1] && rd_acc;
  assign SRAM_DQ = drive ? pipe_data[READ_LAT-1] : 'z;

`ifdef SRAM_PROTOCOL_CHECK_EN
  logic proto_bad;
  assign proto_bad = !SRAM_CE_N &&
                     (!in_range || (!SRAM_WE_N && !SRAM_OE_N) || (!SRAM_WE_N && &SRAM_BE_N));

  always_ff @(posedge clk) begin
    if (!rst) err <= 1'b0;
    else if (proto_bad) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
